// File: rtl/menu_sprite_addr_if.sv
// ----------------------------------------------------------------------------
// menu_sprite_addr_if
// Groups the menu block's control and pixel bus signals.
//   en                 block enable
//   key_up/down/sel    level key states, synchronous to clk
//   choice_ack         consumer acknowledge of a confirmed choice
//   vga_h, vga_v       current 640x480 pixel coordinate
//   addr               sprite ROM address (2-cycle latency)
//   cursor             highlighted entry index
//   choice             confirmed entry index
//   choice_valid       confirmation pending
// master: the side that drives keys and pixels. slave: menu_sprite_addr.
// ----------------------------------------------------------------------------
interface menu_sprite_addr_if #(
    parameter int ADDR_W = 17,
    parameter int CUR_W  = 3
);
    logic              en;
    logic              key_up;
    logic              key_down;
    logic              key_sel;
    logic              choice_ack;
    logic [9:0]        vga_h;
    logic [9:0]        vga_v;
    logic [ADDR_W-1:0] addr;
    logic [CUR_W-1:0]  cursor;
    logic [CUR_W-1:0]  choice;
    logic              choice_valid;

    modport master (
        output en, key_up, key_down, key_sel, choice_ack, vga_h, vga_v,
        input  addr, cursor, choice, choice_valid
    );

    modport slave (
        input  en, key_up, key_down, key_sel, choice_ack, vga_h, vga_v,
        output addr, cursor, choice, choice_valid
    );
endinterface

// File: rtl/menu_sprite_addr.sv
// ----------------------------------------------------------------------------
// menu_sprite_addr
// Vertical menu: key-driven cursor with a confirm/acknowledge handshake, plus
// a 2-stage pipeline that maps the current pixel to a sprite ROM address.
// Ports:
//   clk   system clock, all state on rising edge
//   rst   synchronous active-low reset
//   bus   menu_sprite_addr_if.slave (keys, enable, pixel in; addr, cursor,
//         choice, choice_valid out; choice_ack in)
// ----------------------------------------------------------------------------
module menu_sprite_addr #(
    parameter int NUM_ITEMS  = 5,
    parameter int ITEM_X     = 150,
    parameter int ITEM_Y0    = 40,
    parameter int ITEM_PITCH = 40,
    parameter int ITEM_W     = 21,
    parameter int ITEM_H     = 26,
    parameter int SEL_PAD    = 2,
    parameter int NORM_BASE  = 320,
    parameter int SEL_BASE   = 343,
    parameter int FB_WIDTH   = 320,
    parameter int ADDR_W     = 17,
    parameter int CUR_W      = 3
) (
    input logic                clk,
    input logic                rst,
    menu_sprite_addr_if.slave  bus
);

    typedef enum logic {BROWSE, HOLD} state_t;

    localparam logic [CUR_W-1:0]  LAST_IDX = CUR_W'(NUM_ITEMS - 1);
    localparam logic [ADDR_W-1:0] X_NORM   = ADDR_W'(ITEM_X);
    localparam logic [ADDR_W-1:0] X_SEL    = ADDR_W'(ITEM_X - SEL_PAD);
    localparam logic [ADDR_W-1:0] X_END    = ADDR_W'(ITEM_X + ITEM_W);
    localparam logic [ADDR_W-1:0] H_A      = ADDR_W'(ITEM_H);
    localparam logic [ADDR_W-1:0] NORM_A   = ADDR_W'(NORM_BASE);
    localparam logic [ADDR_W-1:0] SEL_A    = ADDR_W'(SEL_BASE);
    localparam logic [ADDR_W-1:0] FB_A     = ADDR_W'(FB_WIDTH);

    // ------------------------------------------------------------------
    // Key edge detection. History follows the keys even while disabled so
    // a key already held when en rises is not seen as a fresh press.
    // ------------------------------------------------------------------
    logic [2:0] key_q;
    logic       up_p, dn_p, sel_p;

    assign up_p  = bus.en & bus.key_up   & ~key_q[0];
    assign dn_p  = bus.en & bus.key_down & ~key_q[1];
    assign sel_p = bus.en & bus.key_sel  & ~key_q[2];

    // ------------------------------------------------------------------
    // Cursor / choice FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CUR_W-1:0] cursor_q, cursor_d;
    logic [CUR_W-1:0] choice_q, choice_d;
    logic             valid_q, valid_d;

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        choice_d = choice_q;
        valid_d  = valid_q;
        case (state_q)
            BROWSE: begin
                // Confirm wins over a simultaneous move and uses the
                // pre-move cursor.
                if (sel_p) begin
                    choice_d = cursor_q;
                    valid_d  = 1'b1;
                    state_d  = HOLD;
                end else if (up_p && !dn_p) begin
                    cursor_d = (cursor_q == '0) ? LAST_IDX : cursor_q - 1'b1;
                end else if (dn_p && !up_p) begin
                    cursor_d = (cursor_q == LAST_IDX) ? '0 : cursor_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.en && bus.choice_ack) begin
                    valid_d = 1'b0;
                    state_d = BROWSE;
                end
            end
            default: state_d = BROWSE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_q    <= '0;
            state_q  <= BROWSE;
            cursor_q <= '0;
            choice_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            key_q <= {bus.key_sel, bus.key_down, bus.key_up};
            if (bus.en) begin
                state_q  <= state_d;
                cursor_q <= cursor_d;
                choice_q <= choice_d;
                valid_q  <= valid_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address pipeline, stage 1: hit decode and local offsets.
    // Entries do not overlap vertically, so the first row hit is the only one.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] h_a, v_a;
    logic [ADDR_W-1:0] row_top, row_left;
    logic              row_sel;
    logic              s1_hit_d, s1_sel_d;
    logic [ADDR_W-1:0] s1_col_d, s1_row_d;

    assign h_a = ADDR_W'(bus.vga_h[9:1]);
    assign v_a = ADDR_W'(bus.vga_v[9:1]);

    always_comb begin
        s1_hit_d = 1'b0;
        s1_sel_d = 1'b0;
        s1_col_d = '0;
        s1_row_d = '0;
        row_top  = '0;
        row_left = '0;
        row_sel  = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            row_top  = ADDR_W'(ITEM_Y0 + i * ITEM_PITCH);
            row_sel  = (CUR_W'(i) == cursor_q);
            row_left = row_sel ? X_SEL : X_NORM;
            if (!s1_hit_d && bus.en &&
                v_a >= row_top && v_a < row_top + H_A &&
                h_a >= row_left && h_a < X_END) begin
                s1_hit_d = 1'b1;
                s1_sel_d = row_sel;
                // Column offset is measured from the sprite's own left edge,
                // which is SEL_PAD further left for the selected entry.
                s1_col_d = h_a - row_left;
                s1_row_d = v_a - row_top;
            end
        end
    end

    logic              s1_hit_q, s1_sel_q;
    logic [ADDR_W-1:0] s1_col_q, s1_row_q;
    logic [ADDR_W-1:0] s2_addr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_hit_q  <= 1'b0;
            s1_sel_q  <= 1'b0;
            s1_col_q  <= '0;
            s1_row_q  <= '0;
            s2_addr_q <= '0;
        end else begin
            s1_hit_q  <= s1_hit_d;
            s1_sel_q  <= s1_sel_d;
            s1_col_q  <= s1_col_d;
            s1_row_q  <= s1_row_d;
            s2_addr_q <= s1_hit_q ?
                         (s1_sel_q ? SEL_A : NORM_A) + s1_col_q + s1_row_q * FB_A :
                         '0;
        end
    end

    assign bus.addr         = s2_addr_q;
    assign bus.cursor       = cursor_q;
    assign bus.choice       = choice_q;
    assign bus.choice_valid = valid_q;

endmodule
